// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared frame layout and deframer state encoding for the serial link
package serial_link_pkg;

   localparam int FRAME_BITS = 19;
   localparam int SIZE_A_DEF = 7;
   localparam int SIZE_D_DEF = 8;

   // Positions counted from the first transmitted bit of a frame
   localparam int START_POS  = 0;
   localparam int A_MSB_POS  = 1;
   localparam int SEP1_POS   = 8;
   localparam int D_MSB_POS  = 9;
   localparam int SEP2_POS   = 17;
   localparam int STOP_POS   = 18;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      SEP1,
      DATA,
      SEP2,
      STOP
   } deframe_state_e;

endpackage

// File: rtl/serial_in_sync.sv
// rtl/serial_in_sync.sv - matched synchronisers for SerD/SerC plus SerC falling-edge bit strobe
module serial_in_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic reset_n,
   input  logic ser_d_i,
   input  logic ser_c_i,
   output logic strobe_o,
   output logic sample_o
);

   logic [SYNC_STAGES-1:0] d_sync_q;
   logic [SYNC_STAGES-1:0] c_sync_q;
   logic                   c_prev_q;
   logic                   strobe_q;
   logic                   sample_q;

   // Both lines idle high, so every flop resets to 1 except the strobe
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         d_sync_q <= '1;
         c_sync_q <= '1;
         c_prev_q <= 1'b1;
         strobe_q <= 1'b0;
         sample_q <= 1'b1;
      end else begin
         d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], ser_d_i};
         c_sync_q <= {c_sync_q[SYNC_STAGES-2:0], ser_c_i};
         c_prev_q <= c_sync_q[SYNC_STAGES-1];
         strobe_q <= c_prev_q & ~c_sync_q[SYNC_STAGES-1];
         sample_q <= d_sync_q[SYNC_STAGES-1];
      end
   end

   assign strobe_o = strobe_q;
   assign sample_o = sample_q;

endmodule

// File: rtl/serial_in_deframer.sv
// rtl/serial_in_deframer.sv - serial link frame receiver; SERIAL_IN_FRAME_COUNT_EN adds good/error frame counters
module serial_in_deframer
   import serial_link_pkg::*;
#(
   parameter int sizeA       = SIZE_A_DEF,
   parameter int sizeD       = SIZE_D_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 64
) (
   input  logic             clk_in,
   input  logic             reset_n,
   input  logic             SerD,
   input  logic             SerC,
   output logic [sizeA-1:0] A_out,
   output logic [sizeD-1:0] D_out,
   output logic             Valid,
   output logic             FrameErr,
   output logic             Busy
`ifdef SERIAL_IN_FRAME_COUNT_EN
   ,
   output logic [15:0]      GoodCnt,
   output logic [15:0]      ErrCnt
`endif
);

   localparam int BW = $clog2((sizeA > sizeD) ? sizeA : sizeD);
   localparam int TW = $clog2(TIMEOUT);

   logic strobe;
   logic sample;

   serial_in_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .ser_d_i (SerD),
      .ser_c_i (SerC),
      .strobe_o(strobe),
      .sample_o(sample)
   );

   deframe_state_e   state_q, state_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]    to_cnt_q, to_cnt_d;
   logic [TW-1:0]    to_next;
   logic [sizeA-1:0] a_sr_q, a_sr_d;
   logic [sizeD-1:0] d_sr_q, d_sr_d;
   logic [sizeA-1:0] a_out_q, a_out_d;
   logic [sizeD-1:0] d_out_q, d_out_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         to_cnt_q  <= '0;
         a_sr_q    <= '0;
         d_sr_q    <= '0;
         a_out_q   <= '0;
         d_out_q   <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         to_cnt_q  <= to_cnt_d;
         a_sr_q    <= a_sr_d;
         d_sr_q    <= d_sr_d;
         a_out_q   <= a_out_d;
         d_out_q   <= d_out_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign to_next = to_cnt_q + TW'(1);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      to_cnt_d  = to_cnt_q;
      a_sr_d    = a_sr_q;
      d_sr_d    = d_sr_q;
      a_out_d   = a_out_q;
      d_out_d   = d_out_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      // A strobe always wins over the timeout, so Valid and FrameErr stay exclusive
      if (state_q == IDLE || strobe) begin
         to_cnt_d = '0;
      end else if (to_next == TW'(TIMEOUT - 1)) begin
         to_cnt_d = '0;
         err_d    = 1'b1;
         state_d  = IDLE;
         a_sr_d   = '0;
         d_sr_d   = '0;
      end else begin
         to_cnt_d = to_next;
      end

      if (strobe) begin
         unique case (state_q)
            IDLE: begin
               if (!sample) begin
                  state_d   = ADDR;
                  bit_cnt_d = BW'(sizeA - 1);
               end
            end
            ADDR: begin
               a_sr_d = {a_sr_q[sizeA-2:0], sample};
               if (bit_cnt_q == '0) state_d = SEP1;
               else                 bit_cnt_d = bit_cnt_q - BW'(1);
            end
            SEP1: begin
               state_d   = DATA;
               bit_cnt_d = BW'(sizeD - 1);
            end
            DATA: begin
               d_sr_d = {d_sr_q[sizeD-2:0], sample};
               if (bit_cnt_q == '0) state_d = SEP2;
               else                 bit_cnt_d = bit_cnt_q - BW'(1);
            end
            SEP2: state_d = STOP;
            STOP: begin
               if (!sample) begin
                  a_out_d = a_sr_q;
                  d_out_d = d_sr_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign A_out    = a_out_q;
   assign D_out    = d_out_q;
   assign Valid    = valid_q;
   assign FrameErr = err_q;
   assign Busy     = (state_q != IDLE);

`ifdef SERIAL_IN_FRAME_COUNT_EN
   logic [15:0] good_cnt_q;
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         good_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         if (valid_q && good_cnt_q != 16'hFFFF) good_cnt_q <= good_cnt_q + 16'd1;
         if (err_q && err_cnt_q != 16'hFFFF)    err_cnt_q  <= err_cnt_q + 16'd1;
      end
   end

   assign GoodCnt = good_cnt_q;
   assign ErrCnt  = err_cnt_q;
`endif

endmodule
